// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle processor core with one shared ALU.
// Each instruction steps through FETCH, DECODE, EXEC, MEM and WB. Instruction
// and data memories are external and answer through req/ready handshakes
// that may take any number of cycles.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   imem_req/addr            fetch request and address (= PC)
//   imem_ready/rdata         fetch complete, 32-bit instruction word
//   dmem_req/we/addr/wdata   data access request (we=1 store, we=0 load)
//   dmem_ready/rdata         access complete, load data
//   retire                   one-cycle pulse per completed instruction
//   pc_out                   current PC
//   halted                   core stopped (HALT or illegal opcode)
//   illegal                  sticky, the stop was caused by an illegal opcode
//
// state  | meaning
// FETCH  | request imem[PC] until ready, capture IR
// DECODE | latch operands A/B, stop on HALT or illegal opcode
// EXEC   | ALU result / effective address / branch, NOP and BEQ retire here
// MEM    | data access until ready, STORE retires here
// WB     | write rd, retire
// STOP   | halted, no requests, PC frozen until reset
module multicycle_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  retire,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  halted,
    output logic                  illegal
);
    localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd5;
    localparam logic [3:0] OP_STORE = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd8;
    localparam logic [3:0] OP_ADDI  = 4'd9;
    localparam logic [3:0] OP_ILL_MIN = 4'd10;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_ir;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_res;
    logic [ADDR_WIDTH-1:0] r_maddr;
    logic                  r_illegal;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [3:0]            w_op;
    logic [REG_IDX_W-1:0]  w_rd;
    logic [REG_IDX_W-1:0]  w_rs1;
    logic [REG_IDX_W-1:0]  w_rs2;
    logic [DATA_WIDTH-1:0] w_imm_d;
    logic [ADDR_WIDTH-1:0] w_imm_a;
    logic [DATA_WIDTH-1:0] w_alu_b;
    logic [DATA_WIDTH-1:0] w_alu;
    logic [ADDR_WIDTH-1:0] w_ea;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_imem_req;
    logic                  w_unused_ir;

    assign w_op  = r_ir[31:28];
    // Register index is the field modulo NUM_REGS, i.e. its low bits.
    assign w_rd  = r_ir[23 +: REG_IDX_W];
    assign w_rs1 = r_ir[18 +: REG_IDX_W];
    assign w_rs2 = r_ir[13 +: REG_IDX_W];

    // Immediate is sign-extended when the target is wider than 13 bits,
    // otherwise truncated.
    if (DATA_WIDTH > 13) begin : g_imm_d_sx
        assign w_imm_d = {{(DATA_WIDTH-13){r_ir[12]}}, r_ir[12:0]};
    end else begin : g_imm_d_tr
        assign w_imm_d = r_ir[DATA_WIDTH-1:0];
    end

    if (ADDR_WIDTH > 13) begin : g_imm_a_sx
        assign w_imm_a = {{(ADDR_WIDTH-13){r_ir[12]}}, r_ir[12:0]};
    end else begin : g_imm_a_tr
        assign w_imm_a = r_ir[ADDR_WIDTH-1:0];
    end

    // Upper immediate / index bits only matter for wider configurations.
    assign w_unused_ir = ^r_ir;

    // Single ALU: the immediate replaces B for ADDI and address generation.
    assign w_alu_b = (w_op == OP_ADDI || w_op == OP_LOAD || w_op == OP_STORE) ? w_imm_d : r_b;

    always_comb begin
        case (w_op)
            OP_SUB:  w_alu = r_a - w_alu_b;
            OP_AND:  w_alu = r_a & w_alu_b;
            OP_OR:   w_alu = r_a | w_alu_b;
            default: w_alu = r_a + w_alu_b;
        endcase
    end

    if (ADDR_WIDTH <= DATA_WIDTH) begin : g_ea_tr
        assign w_ea = w_alu[ADDR_WIDTH-1:0];
    end else begin : g_ea_zx
        assign w_ea = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, w_alu};
    end

    assign w_pc_inc = r_pc + PC_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        retire      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_op >= OP_ILL_MIN || w_op == OP_HALT) w_state_nxt = S_STOP;
                else                                       w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (w_op)
                    OP_NOP, OP_BEQ: begin
                        retire      = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                    OP_LOAD, OP_STORE: w_state_nxt = S_MEM;
                    default:           w_state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (w_op == OP_STORE);
                if (dmem_ready) begin
                    if (w_op == OP_STORE) begin
                        retire      = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                retire      = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_STOP:  w_state_nxt = S_STOP;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Reset leaves the core in FETCH; masking with rst keeps the fetch
    // request low until reset is released.
    assign imem_req   = w_imem_req & ~rst;
    assign imem_addr  = r_pc;
    assign pc_out     = r_pc;
    assign dmem_addr  = r_maddr;
    assign dmem_wdata = r_b;
    assign halted     = (r_state == S_STOP);
    assign illegal    = r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_maddr   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) r_ir <= imem_rdata;
                end
                S_DECODE: begin
                    r_a <= r_regs[w_rs1];
                    r_b <= r_regs[w_rs2];
                    if (w_op >= OP_ILL_MIN) r_illegal <= 1'b1;
                end
                S_EXEC: begin
                    case (w_op)
                        OP_NOP:            r_pc    <= w_pc_inc;
                        OP_BEQ:            r_pc    <= (r_a == r_b) ? (r_pc + w_imm_a) : w_pc_inc;
                        OP_LOAD, OP_STORE: r_maddr <= w_ea;
                        default:           r_res   <= w_alu;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_op == OP_STORE) r_pc  <= w_pc_inc;
                        else                  r_res <= dmem_rdata;
                    end
                end
                S_WB:    r_pc <= w_pc_inc;
                default: ;
            endcase
        end
    end

    // r0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (r_state == S_WB && w_rd != '0) begin
            r_regs[w_rd] <= r_res;
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
`timescale 1ns/1ps
module tb_multicycle_core;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ready = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          retire;
    logic [AW-1:0] pc_out;
    logic          halted;
    logic          illegal;

    always #5 clk = ~clk;

    multicycle_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .pc_out(pc_out), .halted(halted), .illegal(illegal)
    );

    typedef struct {int addr; int we; int wdata;} dacc_t;

    logic [31:0] imem [32];
    logic [7:0]  dmem [32];
    logic [7:0]  dmem_init [32];
    int          q_fetch[$];
    int          q_ret[$];
    dacc_t       q_dacc[$];
    int          nchecks = 0;
    int          nerrors = 0;
    int          i_mode = 0;    // 0 zero-wait, 1 three waits, 2 random 0..2, 3 never ready
    int          d_mode = 0;
    int          exp_ret, exp_pc, exp_ill;
    int          ret_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input int val);
        nchecks++;
        nerrors++;
        $display("FAIL %s: unexpected event with value %0d, none expected", name, val);
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
        logic [31:0] w;
        w        = '0;
        w[31:28] = op[3:0];
        w[27:23] = rd[4:0];
        w[22:18] = rs1[4:0];
        w[17:13] = rs2[4:0];
        w[12:0]  = imm[12:0];
        return w;
    endfunction

    // Instruction-set level reference: walks the program and queues the
    // fetch addresses, data accesses and retiring PCs the core must produce.
    task automatic model_run();
        int r[32];
        int m[32];
        int pc, npc, op, rd, rs1, rs2, simm, ea, res;
        logic [31:0] w;
        logic [12:0] imm13;
        bit wr;
        for (int i = 0; i < 32; i++) begin r[i] = 0; m[i] = int'(dmem_init[i]); end
        pc = 0; exp_ret = 0; exp_ill = 0; exp_pc = -1;
        for (int step = 0; step < 400; step++) begin
            w = imem[pc];
            op = int'(w[31:28]); rd = int'(w[27:23]); rs1 = int'(w[22:18]); rs2 = int'(w[17:13]);
            imm13 = w[12:0];
            simm = int'($signed(imm13));
            q_fetch.push_back(pc);
            if (op == 8 || op >= 10) begin
                exp_ill = (op >= 10) ? 1 : 0;
                exp_pc  = pc;
                break;
            end
            npc = (pc + 1) & 31; wr = 0; res = 0;
            case (op)
                1: begin res = r[rs1] + r[rs2]; wr = 1; end
                2: begin res = r[rs1] - r[rs2]; wr = 1; end
                3: begin res = r[rs1] & r[rs2]; wr = 1; end
                4: begin res = r[rs1] | r[rs2]; wr = 1; end
                9: begin res = r[rs1] + simm;   wr = 1; end
                5: begin
                    ea = (r[rs1] + simm) & 31;
                    q_dacc.push_back('{ea, 0, 0});
                    res = m[ea]; wr = 1;
                end
                6: begin
                    ea = (r[rs1] + simm) & 31;
                    q_dacc.push_back('{ea, 1, r[rs2]});
                    m[ea] = r[rs2];
                end
                7: if (r[rs1] == r[rs2]) npc = (pc + simm) & 31;
                default: ;
            endcase
            if (wr && rd != 0) r[rd] = res & 255;
            q_ret.push_back(pc);
            exp_ret++;
            pc = npc;
        end
    endtask

    function automatic int pick(input int mode);
        case (mode)
            0:       return 0;
            1:       return 3;
            2:       return int'($urandom_range(0, 2));
            default: return 1000000;
        endcase
    endfunction

    // Memory responders and scoreboard monitor for the memory ports.
    int            i_cnt = 0, i_dly = 0, d_cnt = 0, d_dly = 0;
    bit            i_wait = 0, d_wait = 0;
    logic [AW-1:0] i_hold_addr, d_hold_addr;
    logic          d_hold_we;
    logic [DW-1:0] d_hold_wd;

    always @(negedge clk) begin
        if (rst) begin
            imem_ready = 1'b0; dmem_ready = 1'b0;
            i_wait = 0; d_wait = 0; i_cnt = 0; d_cnt = 0;
            i_dly = pick(i_mode); d_dly = pick(d_mode);
        end else begin
            if (halted) chk("no_req_when_halted", {imem_req, dmem_req}, 0);
            imem_ready = 1'b0;
            if (imem_req) begin
                if (i_wait) chk("imem_addr_stable", imem_addr, i_hold_addr);
                if (i_cnt >= i_dly) begin
                    imem_ready = 1'b1;
                    imem_rdata = imem[imem_addr];
                    if (q_fetch.size() == 0) extra("fetch", int'(imem_addr));
                    else chk("fetch_addr", imem_addr, q_fetch.pop_front());
                    i_cnt = 0; i_wait = 0; i_dly = pick(i_mode);
                end else begin
                    i_cnt++; i_wait = 1; i_hold_addr = imem_addr;
                end
            end else if (i_mode == 2) begin
                imem_ready = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end
            dmem_ready = 1'b0;
            if (dmem_req) begin
                if (d_wait) begin
                    chk("dmem_addr_stable", dmem_addr, d_hold_addr);
                    chk("dmem_we_stable", dmem_we, d_hold_we);
                    chk("dmem_wdata_stable", dmem_wdata, d_hold_wd);
                end
                if (d_cnt >= d_dly) begin
                    dacc_t e;
                    dmem_ready = 1'b1;
                    if (q_dacc.size() == 0) extra("dmem_access", int'(dmem_addr));
                    else begin
                        e = q_dacc.pop_front();
                        chk("dmem_addr", dmem_addr, e.addr);
                        chk("dmem_we", dmem_we, e.we);
                        if (e.we != 0) chk("dmem_wdata", dmem_wdata, e.wdata);
                    end
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    else         dmem_rdata = dmem[dmem_addr];
                    d_cnt = 0; d_wait = 0; d_dly = pick(d_mode);
                end else begin
                    d_cnt++; d_wait = 1;
                    d_hold_addr = dmem_addr; d_hold_we = dmem_we; d_hold_wd = dmem_wdata;
                end
            end else if (d_mode == 2) begin
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = 8'($urandom);
            end
        end
    end

    // Retire monitor, sampled after the responders have settled ready.
    always @(negedge clk) begin
        #3;
        if (!rst && retire) begin
            ret_cnt++;
            if (q_ret.size() == 0) extra("retire", int'(pc_out));
            else chk("retire_pc", pc_out, q_ret.pop_front());
        end
    end

    task automatic clear_prog();
        for (int a = 0; a < 32; a++) begin
            imem[a] = enc(8, 0, 0, 0, 0);
            dmem_init[a] = 8'h00;
        end
    endtask

    task automatic start_prog(input int im, input int dm);
        rst = 1'b1;
        i_mode = im; d_mode = dm;
        q_fetch.delete(); q_ret.delete(); q_dacc.delete();
        ret_cnt = 0;
        for (int a = 0; a < 32; a++) dmem[a] = dmem_init[a];
        model_run();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic run_prog(input string name, input int im, input int dm, input int exp_cyc);
        int cyc;
        start_prog(im, dm);
        cyc = 0;
        while (!halted && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_halted"}, halted, 1);
        if (exp_cyc >= 0) chk({name, "_cycles_to_halt"}, cyc, exp_cyc);
        repeat (5) @(negedge clk);
        #4;
        chk({name, "_illegal"}, illegal, exp_ill);
        chk({name, "_pc_frozen"}, pc_out, exp_pc);
        chk({name, "_retire_count"}, ret_cnt, exp_ret);
        chk({name, "_fetch_q_empty"}, q_fetch.size(), 0);
        chk({name, "_dacc_q_empty"}, q_dacc.size(), 0);
    endtask

    task automatic gen_random(input bit with_illegal);
        int n, op, imm;
        int ops[9];
        int regs[8];
        ops  = '{0, 1, 2, 3, 4, 5, 6, 7, 9};
        regs = '{0, 1, 2, 3, 4, 5, 6, 31};
        clear_prog();
        n = int'($urandom_range(8, 20));
        for (int a = 0; a < n; a++) begin
            op  = ops[$urandom_range(0, 8)];
            imm = int'($urandom_range(0, 8191));
            if (op == 7) imm = int'($urandom_range(1, 3));
            imem[a] = enc(op, regs[$urandom_range(0, 7)], regs[$urandom_range(0, 7)],
                          regs[$urandom_range(0, 7)], imm);
        end
        if (with_illegal) imem[$urandom_range(2, n - 1)] = enc(int'($urandom_range(10, 15)), 1, 2, 3, 4);
        for (int a = 0; a < 32; a++) dmem_init[a] = 8'($urandom);
    endtask

    initial begin
        int cyc;
        // ADDI/ADDI/ADD/HALT, zero-wait and with three-cycle fetch waits
        clear_prog();
        imem[0] = enc(9, 1, 0, 0, 5);
        imem[1] = enc(9, 2, 0, 0, 3);
        imem[2] = enc(1, 3, 1, 2, 0);
        imem[3] = enc(8, 0, 0, 0, 0);
        run_prog("basic", 0, 0, 14);
        chk("basic_retires_3", ret_cnt, 3);
        chk("basic_not_illegal", illegal, 0);
        run_prog("slow_fetch", 1, 0, 26);

        // Arithmetic wrap, r0 write discard, store/load round trip
        clear_prog();
        for (int a = 0; a < 32; a++) dmem_init[a] = 8'h33;
        imem[0]  = enc(9, 1, 0, 0, 2);
        imem[1]  = enc(9, 2, 0, 0, 5);
        imem[2]  = enc(2, 3, 1, 2, 0);
        imem[3]  = enc(6, 0, 0, 3, 0);
        imem[4]  = enc(9, 1, 0, 0, -1);
        imem[5]  = enc(6, 0, 0, 1, 1);
        imem[6]  = enc(9, 0, 0, 0, 7);
        imem[7]  = enc(6, 0, 0, 0, 2);
        imem[8]  = enc(9, 1, 0, 0, 3);
        imem[9]  = enc(9, 2, 0, 0, 'h5A);
        imem[10] = enc(6, 0, 1, 2, 4);
        imem[11] = enc(5, 4, 1, 0, 4);
        imem[12] = enc(6, 0, 0, 4, 8);
        run_prog("datapath", 0, 0, -1);
        chk("sub_wrap_fd", dmem[0], 8'hFD);
        chk("addi_minus1_ff", dmem[1], 8'hFF);
        chk("r0_stays_zero", dmem[2], 8'h00);
        chk("store_at_7", dmem[7], 8'h5A);
        chk("load_back_5a", dmem[8], 8'h5A);

        // BEQ backwards from PC 2 to PC 0, taken once
        clear_prog();
        imem[0] = enc(9, 3, 1, 0, 0);
        imem[1] = enc(9, 1, 0, 0, 1);
        imem[2] = enc(7, 0, 3, 0, -2);
        imem[3] = enc(6, 0, 0, 3, 5);
        run_prog("beq_back", 2, 2, -1);
        chk("beq_back_store", dmem[5], 8'h01);

        // Not-taken BEQ at PC 31 wraps to 0
        clear_prog();
        imem[0]  = enc(7, 0, 1, 0, 2);
        imem[2]  = enc(9, 1, 0, 0, 1);
        imem[3]  = enc(7, 0, 0, 0, 28);
        imem[31] = enc(7, 0, 1, 0, 5);
        run_prog("pc_wrap", 0, 0, -1);
        chk("pc_wrap_final_pc", pc_out, 1);

        // Illegal opcode traps
        clear_prog();
        imem[0] = enc(9, 1, 0, 0, 1);
        imem[1] = enc(12, 1, 1, 1, 0);
        imem[2] = enc(9, 2, 0, 0, 1);
        run_prog("illegal_op", 2, 2, -1);
        chk("illegal_flag_set", illegal, 1);
        chk("illegal_retires_1", ret_cnt, 1);

        // Reset while a store is waiting on dmem
        clear_prog();
        imem[0] = enc(9, 1, 0, 0, 3);
        imem[1] = enc(9, 2, 0, 0, 'h5A);
        imem[2] = enc(6, 0, 1, 2, 4);
        start_prog(0, 3);
        cyc = 0;
        while (!dmem_req && cyc < 50) begin @(negedge clk); cyc++; end
        chk("rst_mid_dmem_req_seen", dmem_req, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_drops_dmem_req", dmem_req, 0);
        chk("rst_no_imem_req", imem_req, 0);
        chk("rst_pc_zero", pc_out, 0);
        chk("rst_no_halt", halted, 0);
        run_prog("after_rst", 0, 0, -1);
        chk("after_rst_store", dmem[7], 8'h5A);

        // Random programs with random memory latency and spurious ready
        for (int t = 0; t < 10; t++) begin
            gen_random(t % 4 == 3);
            run_prog($sformatf("rand%0d", t), 2, 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", nchecks, nerrors);
        $fatal(1, "watchdog expired");
    end

endmodule
